// File: rtl/meduram_bank.sv
// meduram_bank: core-clock storage bank with two write ports and one read port.
// Clears itself after reset (INIT), then serves read-first reads with
// read/write and write/write conflict flags (RUN).
module meduram_bank #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  wren0,
  input  logic [ADDR_WIDTH-1:0] wraddr0,
  input  logic [DATA_WIDTH-1:0] wrdata0,
  input  logic                  wren1,
  input  logic [ADDR_WIDTH-1:0] wraddr1,
  input  logic [DATA_WIDTH-1:0] wrdata1,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  output logic [DATA_WIDTH-1:0] rddata,
  output logic [1:0]            rdcollision,
  output logic                  wrcollision,
  output logic                  init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    ww_hit;
  logic [1:0]              rw_hit;

  // Both write ports on one address; port 0 wins, port 1 is dropped.
  assign ww_hit = wren0 & wren1 & (wraddr0 == wraddr1);
  // Per-port read/write overlap; a losing port 1 still counts.
  assign rw_hit = {wren1 & (wraddr1 == rdaddr), wren0 & (wraddr0 == rdaddr)};

  // Storage: clear one word per cycle in INIT, user writes only in RUN.
  // Port 0 is written last so it wins even if the gating were removed.
  always_ff @(posedge aclk) begin
    if (!srst) begin
      if (state == S_INIT) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wren1 && !ww_hit) mem[wraddr1] <= wrdata1;
        if (wren0)            mem[wraddr0] <= wrdata0;
      end
    end
  end

  // Control FSM plus registered read response and collision pulse.
  // Reads sample mem before this edge's writes land (read-first).
  always_ff @(posedge aclk) begin
    if (srst) begin
      state       <= S_INIT;
      clr_cnt     <= '0;
      init_done   <= 1'b0;
      rddata      <= '0;
      rdcollision <= '0;
      wrcollision <= 1'b0;
    end else if (state == S_INIT) begin
      wrcollision <= 1'b0;
      if (clr_cnt == LAST_ADDR) begin
        state     <= S_RUN;
        init_done <= 1'b1;
      end else begin
        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      end
      // Memory not ready yet: answer with zero data and both flags set
      // so the bridge returns an error instead of dropping the read.
      if (rden) begin
        rddata      <= '0;
        rdcollision <= 2'b11;
      end
    end else begin
      wrcollision <= ww_hit;
      if (rden) begin
        rddata      <= mem[rdaddr];
        rdcollision <= rw_hit;
      end
    end
  end

endmodule

// File: tb/tb_meduram_bank.sv
// tb_meduram_bank: table-driven directed vectors for meduram_bank.
// Each record holds one cycle of inputs and the outputs expected right after
// that cycle's rising edge.
module tb_meduram_bank;

  logic       aclk = 1'b0;
  logic       srst = 1'b1;
  logic       wren0 = 1'b0, wren1 = 1'b0, rden = 1'b0;
  logic [2:0] wraddr0 = '0, wraddr1 = '0, rdaddr = '0;
  logic [7:0] wrdata0 = '0, wrdata1 = '0;
  logic [7:0] rddata;
  logic [1:0] rdcollision;
  logic       wrcollision, init_done;

  always #5 aclk = ~aclk;

  meduram_bank #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .aclk(aclk), .srst(srst),
    .wren0(wren0), .wraddr0(wraddr0), .wrdata0(wrdata0),
    .wren1(wren1), .wraddr1(wraddr1), .wrdata1(wrdata1),
    .rden(rden), .rdaddr(rdaddr),
    .rddata(rddata), .rdcollision(rdcollision),
    .wrcollision(wrcollision), .init_done(init_done)
  );

  typedef struct {
    logic       s;
    logic       w0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       w1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       rd;
    logic [2:0] ra;
    logic [7:0] e_data;
    logic [1:0] e_rcol;
    logic       e_wcol;
    logic       e_done;
  } vec_t;

  vec_t vecs [80];
  int   nv = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic add(input logic s,
                     input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                     input logic w1, input logic [2:0] a1, input logic [7:0] d1,
                     input logic rd, input logic [2:0] ra,
                     input logic [7:0] ed, input logic [1:0] ec,
                     input logic ew, input logic edn);
    vecs[nv] = '{s, w0, a0, d0, w1, a1, d1, rd, ra, ed, ec, ew, edn};
    nv++;
  endtask

  // Drive one cycle, sample 1 time unit after the edge, compare all outputs.
  task automatic apply(input vec_t v, input int id);
    srst = v.s;
    wren0 = v.w0; wraddr0 = v.a0; wrdata0 = v.d0;
    wren1 = v.w1; wraddr1 = v.a1; wrdata1 = v.d1;
    rden = v.rd;  rdaddr = v.ra;
    @(posedge aclk);
    #1;
    n_vec++;
    if (rddata !== v.e_data) begin
      n_miss++;
      $display("FAIL vec%0d rddata got %h want %h", id, rddata, v.e_data);
    end
    if (rdcollision !== v.e_rcol) begin
      n_miss++;
      $display("FAIL vec%0d rdcollision got %b want %b", id, rdcollision, v.e_rcol);
    end
    if (wrcollision !== v.e_wcol) begin
      n_miss++;
      $display("FAIL vec%0d wrcollision got %b want %b", id, wrcollision, v.e_wcol);
    end
    if (init_done !== v.e_done) begin
      n_miss++;
      $display("FAIL vec%0d init_done got %b want %b", id, init_done, v.e_done);
    end
  endtask

  initial begin
    vec_t v;
    // --- table: reset, INIT reads, RUN function ---
    // reset held two cycles
    add(1, 0,0,0, 0,0,0, 1,5, 8'h00,2'b00,0,0);
    add(1, 0,0,0, 0,0,0, 1,5, 8'h00,2'b00,0,0);
    // INIT: 8 reads of addr 5, writes ignored (incl. a would-be collision)
    for (int i = 0; i < 8; i++) begin
      if (i == 2)      add(0, 1,5,8'hFF, 0,0,0,     1,5, 8'h00,2'b11,0,0);
      else if (i == 3) add(0, 1,5,8'hEE, 1,5,8'hDD, 1,5, 8'h00,2'b11,0,0);
      else             add(0, 0,0,0,     0,0,0,     1,5, 8'h00,2'b11,0,(i == 7));
    end
    // first RUN read: cleared, INIT writes did not land
    add(0, 0,0,0, 0,0,0, 1,5, 8'h00,2'b00,0,1);
    // basic write then read
    add(0, 1,3,8'hA5, 0,0,0, 0,0, 8'h00,2'b00,0,1);
    add(0, 0,0,0,     0,0,0, 1,3, 8'hA5,2'b00,0,1);
    // read-during-write via port 1
    add(0, 1,2,8'h11, 0,0,0,     0,0, 8'hA5,2'b00,0,1);
    add(0, 0,0,0,     1,2,8'h22, 1,2, 8'h11,2'b10,0,1);
    add(0, 0,0,0,     0,0,0,     1,2, 8'h22,2'b00,0,1);
    // write/write collision on addr 7 while reading it
    add(0, 1,7,8'h33, 1,7,8'h44, 1,7, 8'h00,2'b11,1,1);
    add(0, 0,0,0,     0,0,0,     1,7, 8'h33,2'b00,0,1);
    // fill mem[i] = i + 0x10 two words per cycle; outputs hold
    for (int i = 0; i < 8; i += 2)
      add(0, 1,3'(i),8'(i + 16), 1,3'(i + 1),8'(i + 17), 0,0, 8'h33,2'b00,0,1);
    // back-to-back reads 0..7
    for (int i = 0; i < 8; i++)
      add(0, 0,0,0, 0,0,0, 1,3'(i), 8'(i + 16),2'b00,0,1);
    // port-0-only overlap, then two non-colliding writes
    add(0, 1,4,8'h55, 0,0,0,     1,4, 8'h14,2'b01,0,1);
    add(0, 1,1,8'h66, 1,6,8'h77, 1,6, 8'h16,2'b10,0,1);
    add(0, 0,0,0,     0,0,0,     1,4, 8'h55,2'b00,0,1);
    add(0, 0,0,0,     0,0,0,     1,1, 8'h66,2'b00,0,1);
    add(0, 0,0,0,     0,0,0,     1,6, 8'h77,2'b00,0,1);
    // rden low: outputs hold
    add(0, 0,0,0,     0,0,0,     0,6, 8'h77,2'b00,0,1);

    for (int i = 0; i < nv; i++) apply(vecs[i], i);

    // --- hand sequence: reset mid-operation with memory filled ---
    v = '{1'b1, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b1,3'd0, 8'h00,2'b00,1'b0,1'b0};
    apply(v, 100);
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0, 1'b1,3'(i),8'hC3, 1'b0,3'd0,8'h00, 1'b1,3'(i),
            8'h00,2'b11,1'b0,(i == 7)};
      apply(v, 101 + i);
    end
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0, 1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b1,3'(i),
            8'h00,2'b00,1'b0,1'b1};
      apply(v, 109 + i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
